// File: rtl/node_info_ctrl_pkg.sv
// node_info_pkg
// Shared definitions for the node_info_ctrl slice: received packet-type
// codes and the controller FSM state type.
package node_info_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;  // heartbeat from sink side
    localparam logic [2:0] PKT_CHE  = 3'b001;  // cluster-head election
    localparam logic [2:0] PKT_INV  = 3'b010;  // invitation
    localparam logic [2:0] PKT_CHT  = 3'b100;  // cluster-head timeslot
    localparam logic [2:0] PKT_DATA = 3'b101;  // data, closes the HB window

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DIV  = 1'b1
    } ni_state_e;

endpackage

// File: rtl/node_info_ctrl_q_divider.sv
// q_divider
// Restoring unsigned divider, one quotient bit per clock.
// A start pulse latches the operands; the quotient is produced on the
// WIDTH-th following edge, flagged by the done strobe for that cycle.
//
// Ports:
//   clk       system clock
//   nrst      asynchronous active-low reset (aborts a running divide)
//   start     one-cycle start strobe, operands sampled on that edge
//   dividend  numerator
//   divisor   denominator (caller guarantees non-zero)
//   done      high in the cycle whose closing edge finishes the divide
//   quotient  quotient, valid while done is high
module q_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rem_nxt;
    logic [WIDTH-1:0] quo_nxt;

    // quo starts as the dividend and shifts out its MSB each step while the
    // new quotient bit shifts in at the bottom.
    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        ge      = (shifted >= {1'b0, dvs});
        // When ge holds the true difference is below dvs, so the low WIDTH
        // bits of the modular subtraction are exact.
        diff    = shifted[WIDTH-1:0] - dvs;
        rem_nxt = ge ? diff : shifted[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], ge};
    end

    assign done     = (cnt == CW'(1));
    assign quotient = quo_nxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
            rem <= '0;
            quo <= '0;
            dvs <= '0;
        end else if (start) begin
            cnt <= CW'(WIDTH);
            rem <= '0;
            quo <= dividend;
            dvs <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

endmodule

// File: rtl/node_info_ctrl.sv
// node_info_ctrl
// Per-node state controller for the EER-RL clustering datapath. Decodes
// received packets and keeps the hop distance to the sink, the initial
// Q-value (energy / hops via a sequential divider), cluster role, TDMA
// timeslot and a low-energy flag.
//
// Optional feature: define NODE_INFO_SHORTEST_PATH_EN to let a heartbeat
// with a strictly shorter hop count replace the locked one.
//
// Ports:
//   clk            system clock
//   nrst           asynchronous active-low reset
//   en_MNI         one-cycle packet strobe, ignored while busy
//   round_start    one-cycle new-round pulse
//   fPktType       packet type
//   energy         residual energy (2.14 fixed point at 16 bits)
//   destinationID  packet destination ID
//   hops           hop count carried in the packet
//   timeslot       assigned timeslot, low TS_WIDTH bits used
//   e_threshold    low-energy threshold
//   myNodeID       constant NODE_ID
//   hopsFromSink   recorded hop distance
//   myQValue       initial Q-value
//   q_valid        myQValue is current
//   busy           divider running
//   role           1 = cluster head
//   myTimeslot     member timeslot
//   ts_valid       myTimeslot assigned this round
//   low_E          energy below threshold
//
// State   | meaning
// --------+----------------------------------------------
// ST_IDLE | accepting packets
// ST_DIV  | computing energy / hops, packets dropped
module node_info_ctrl
    import node_info_pkg::*;
#(
    parameter int                    WORD_WIDTH = 16,
    parameter logic [WORD_WIDTH-1:0] NODE_ID    = 16'h000C,
    parameter int                    TS_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en_MNI,
    input  logic                  round_start,
    input  logic [2:0]            fPktType,
    input  logic [WORD_WIDTH-1:0] energy,
    input  logic [WORD_WIDTH-1:0] destinationID,
    input  logic [WORD_WIDTH-1:0] hops,
    input  logic [WORD_WIDTH-1:0] timeslot,
    input  logic [WORD_WIDTH-1:0] e_threshold,
    output logic [WORD_WIDTH-1:0] myNodeID,
    output logic [WORD_WIDTH-1:0] hopsFromSink,
    output logic [WORD_WIDTH-1:0] myQValue,
    output logic                  q_valid,
    output logic                  busy,
    output logic                  role,
    output logic [TS_WIDTH-1:0]   myTimeslot,
    output logic                  ts_valid,
    output logic                  low_E
);

    ni_state_e state;
    ni_state_e state_nxt;

    logic                  hb_lock;
    logic                  accept;
    logic                  for_me;
    logic                  hb_take;
    logic                  start_div;
    logic                  role_eff;
    logic                  div_done;
    logic [WORD_WIDTH-1:0] div_quotient;
    logic                  unused_ts;

    assign myNodeID  = NODE_ID;
    assign busy      = (state == ST_DIV);
    assign accept    = en_MNI && !busy;
    assign for_me    = (destinationID == NODE_ID);
    assign unused_ts = ^timeslot[WORD_WIDTH-1:TS_WIDTH];

    // round_start is applied before a coincident packet, so the packet sees
    // the role as already cleared.
    assign role_eff  = role && !round_start;

`ifdef NODE_INFO_SHORTEST_PATH_EN
    assign hb_take = !hb_lock || (hops < hopsFromSink);
`else
    assign hb_take = !hb_lock;
`endif

    always_comb begin
        state_nxt = state;
        start_div = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept && (fPktType == PKT_HB) && hb_take && (hops != '0)) begin
                    start_div = 1'b1;
                    state_nxt = ST_DIV;
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    q_divider #(
        .WIDTH (WORD_WIDTH)
    ) u_q_divider (
        .clk      (clk),
        .nrst     (nrst),
        .start    (start_div),
        .dividend (energy),
        .divisor  (hops),
        .done     (div_done),
        .quotient (div_quotient)
    );

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hopsFromSink <= '1;
            myQValue     <= '0;
            q_valid      <= 1'b0;
            role         <= 1'b0;
            myTimeslot   <= '0;
            ts_valid     <= 1'b0;
            low_E        <= 1'b0;
            hb_lock      <= 1'b0;
        end else begin
            if (busy && div_done) begin
                myQValue <= div_quotient;
                q_valid  <= 1'b1;
            end

            if (round_start) begin
                role       <= 1'b0;
                ts_valid   <= 1'b0;
                myTimeslot <= '0;
            end

            if (accept) begin
                low_E <= (energy < e_threshold);
                case (fPktType)
                    PKT_HB: begin
                        if (hb_take) begin
                            hopsFromSink <= hops;
                            hb_lock      <= 1'b1;
                            if (hops == '0) begin
                                myQValue <= energy;
                                q_valid  <= 1'b1;
                            end else begin
                                q_valid  <= 1'b0;
                            end
                        end
                    end
                    PKT_CHE: begin
                        if (for_me) begin
                            role <= 1'b1;
                        end
                    end
                    PKT_CHT: begin
                        if (!role_eff && for_me) begin
                            myTimeslot <= timeslot[TS_WIDTH-1:0];
                            ts_valid   <= 1'b1;
                        end
                    end
                    PKT_DATA: begin
                        hb_lock <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_node_info_ctrl.sv
module tb_node_info_ctrl;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en_MNI;
    logic        round_start;
    logic [2:0]  fPktType;
    logic [15:0] energy;
    logic [15:0] destinationID;
    logic [15:0] hops;
    logic [15:0] timeslot;
    logic [15:0] e_threshold;
    logic [15:0] myNodeID;
    logic [15:0] hopsFromSink;
    logic [15:0] myQValue;
    logic        q_valid;
    logic        busy;
    logic        role;
    logic [7:0]  myTimeslot;
    logic        ts_valid;
    logic        low_E;

    always #5 clk = ~clk;

    node_info_ctrl dut (
        .clk           (clk),
        .nrst          (nrst),
        .en_MNI        (en_MNI),
        .round_start   (round_start),
        .fPktType      (fPktType),
        .energy        (energy),
        .destinationID (destinationID),
        .hops          (hops),
        .timeslot      (timeslot),
        .e_threshold   (e_threshold),
        .myNodeID      (myNodeID),
        .hopsFromSink  (hopsFromSink),
        .myQValue      (myQValue),
        .q_valid       (q_valid),
        .busy          (busy),
        .role          (role),
        .myTimeslot    (myTimeslot),
        .ts_valid      (ts_valid),
        .low_E         (low_E)
    );

    typedef struct {
        logic [15:0] hops;
        logic [15:0] q;
        logic        qv;
        logic        busy;
        logic        role;
        logic [7:0]  ts;
        logic        tsv;
        logic        lowe;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [15:0] m_hops;
    logic [15:0] m_q;
    logic [15:0] m_qpend;
    logic        m_qv;
    logic        m_busy;
    logic        m_role;
    logic [7:0]  m_ts;
    logic        m_tsv;
    logic        m_lowe;
    logic        m_lock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_hops = 16'hFFFF; m_q = 16'h0; m_qpend = 16'h0; m_qv = 1'b0;
        m_busy = 1'b0; m_role = 1'b0; m_ts = 8'h0; m_tsv = 1'b0;
        m_lowe = 1'b0; m_lock = 1'b0;
    endtask

    task automatic push_exp();
        exp_t e;
        e.hops = m_hops; e.q = m_q; e.qv = m_qv; e.busy = m_busy;
        e.role = m_role; e.ts = m_ts; e.tsv = m_tsv; e.lowe = m_lowe;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".id"},    32'(myNodeID),     32'h000C);
            chk({tag, ".hops"},  32'(hopsFromSink), 32'(e.hops));
            chk({tag, ".q"},     32'(myQValue),     32'(e.q));
            chk({tag, ".qv"},    32'(q_valid),      32'(e.qv));
            chk({tag, ".busy"},  32'(busy),         32'(e.busy));
            chk({tag, ".role"},  32'(role),         32'(e.role));
            chk({tag, ".ts"},    32'(myTimeslot),   32'(e.ts));
            chk({tag, ".tsv"},   32'(ts_valid),     32'(e.tsv));
            chk({tag, ".lowE"},  32'(low_E),        32'(e.lowe));
        end
    endtask

    task automatic model_pkt(input logic [2:0] t, input logic [15:0] dest, input logic [15:0] h,
                             input logic [15:0] e, input logic [15:0] ts, input bit rs,
                             output bit ds);
        bit ok;
        ds = 1'b0;
        if (rs) begin
            m_role = 1'b0; m_tsv = 1'b0; m_ts = 8'h0;
        end
        if (!m_busy) begin
            m_lowe = (e < e_threshold);
            case (t)
                3'b000: begin
                    ok = !m_lock;
`ifdef NODE_INFO_SHORTEST_PATH_EN
                    if (m_lock && (h < m_hops)) ok = 1'b1;
`endif
                    if (ok) begin
                        m_hops = h;
                        m_lock = 1'b1;
                        if (h == 16'h0) begin
                            m_q = e; m_qv = 1'b1;
                        end else begin
                            m_busy = 1'b1; m_qv = 1'b0; m_qpend = e / h; ds = 1'b1;
                        end
                    end
                end
                3'b001: if (dest == 16'h000C) m_role = 1'b1;
                3'b100: if (!m_role && dest == 16'h000C) begin
                    m_ts = ts[7:0]; m_tsv = 1'b1;
                end
                3'b101: m_lock = 1'b0;
                default: ;
            endcase
        end
    endtask

    task automatic wait_div(input string tag, input bit inject);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 64) begin
            cnt++;
            if (inject && cnt == 5) begin
                fPktType = 3'b001; destinationID = 16'h000C; energy = 16'h0100; en_MNI = 1'b1;
            end else begin
                en_MNI = 1'b0;
            end
            @(negedge clk);
        end
        en_MNI = 1'b0;
        chk({tag, ".busy_cycles"}, 32'(cnt), 32'd16);
        m_busy = 1'b0; m_q = m_qpend; m_qv = 1'b1;
        push_exp();
        pop_check({tag, ".done"});
    endtask

    task automatic send(input string tag, input logic [2:0] t, input logic [15:0] dest,
                        input logic [15:0] h, input logic [15:0] e, input logic [15:0] ts,
                        input bit rs, input bit wait_done, input bit inject);
        bit ds;
        @(negedge clk);
        fPktType = t; destinationID = dest; hops = h; energy = e; timeslot = ts;
        en_MNI = 1'b1; round_start = rs;
        model_pkt(t, dest, h, e, ts, rs, ds);
        push_exp();
        @(posedge clk);
        #1;
        en_MNI = 1'b0; round_start = 1'b0;
        @(negedge clk);
        pop_check(tag);
        if (ds && wait_done) wait_div(tag, inject);
    endtask

    task automatic pulse_rs(input string tag);
        @(negedge clk);
        round_start = 1'b1;
        m_role = 1'b0; m_tsv = 1'b0; m_ts = 8'h0;
        push_exp();
        @(posedge clk);
        #1;
        round_start = 1'b0;
        @(negedge clk);
        pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0; en_MNI = 1'b0; round_start = 1'b0; fPktType = 3'b0;
        energy = 16'h0; destinationID = 16'h0; hops = 16'h0; timeslot = 16'h0;
        e_threshold = 16'h3333;
        model_reset();
        repeat (2) @(negedge clk);
        push_exp();
        pop_check("reset");
        nrst = 1'b1;

        send("hb1",       3'b000, 16'h0000, 16'd1, 16'h8000, 16'h0, 0, 1, 0);
        send("hb2_drop",  3'b000, 16'h0000, 16'd2, 16'h7FC0, 16'h0, 0, 1, 0);
        send("che_other", 3'b001, 16'h0020, 16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("inv",       3'b010, 16'h0020, 16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("che_me",    3'b001, 16'h000C, 16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("cht_ch",    3'b100, 16'h000C, 16'd0, 16'h8000, 16'd4, 0, 1, 0);
        pulse_rs("rs");
        send("cht_mem",   3'b100, 16'h000C, 16'd0, 16'h8000, 16'hAB05, 0, 1, 0);
        send("data",      3'b101, 16'd14,   16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("hb3",       3'b000, 16'h0000, 16'd3, 16'h6000, 16'h0, 0, 1, 1);
        send("data_lowE", 3'b101, 16'd14,   16'd0, 16'h3000, 16'h0, 0, 1, 0);
        send("thr_edge",  3'b010, 16'd14,   16'd0, 16'h3333, 16'h0, 0, 1, 0);
        send("rs_che",    3'b001, 16'h000C, 16'd0, 16'h8000, 16'h0, 1, 1, 0);
        send("rs_cht",    3'b100, 16'h000C, 16'd0, 16'h8000, 16'd9, 1, 1, 0);
        send("data2",     3'b101, 16'd14,   16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("hb_h0",     3'b000, 16'h0000, 16'd0, 16'h1234, 16'h0, 0, 1, 0);
        send("data3",     3'b101, 16'd14,   16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("hb4",       3'b000, 16'h0000, 16'd4, 16'h4000, 16'h0, 0, 1, 0);
        send("hb_short",  3'b000, 16'h0000, 16'd2, 16'h4000, 16'h0, 0, 1, 0);
        send("data4",     3'b101, 16'd14,   16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("hb7",       3'b000, 16'h0000, 16'd7, 16'h7FFF, 16'h0, 0, 1, 0);
        send("data5",     3'b101, 16'd14,   16'd0, 16'h8000, 16'h0, 0, 1, 0);
        send("hb5_abort", 3'b000, 16'h0000, 16'd5, 16'h7000, 16'h0, 0, 0, 0);

        repeat (3) @(negedge clk);
        nrst = 1'b0;
        #2;
        model_reset();
        push_exp();
        pop_check("rst_mid");
        @(negedge clk);
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        push_exp();
        pop_check("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
